// File: rtl/present_core_hs.sv
// present_core_hs: iterative PRESENT-80/128 encrypt/decrypt engine with valid/ready handshakes and a decryption key cache
module present_core_hs #(
    parameter int KEY_WIDTH  = 128,
    parameter int DKEY_CACHE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_decrypt,
    input  logic [63:0]          in_data,
    input  logic [KEY_WIDTH-1:0] in_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_data
);
    localparam int KW = KEY_WIDTH;
    localparam int RC_LO = (KW == 80) ? 15 : 62;
    localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] ISBOX = 64'hA970_364B_D21C_8FE5;

    if (KW != 80 && KW != 128) begin : g_bad_width
        $error("present_core_hs: KEY_WIDTH must be 80 or 128");
    end

    typedef enum logic [2:0] {IDLE, KEXP, ENC, DEC, DONE} fsm_t;

    fsm_t            r_fsm, w_nxt;
    logic [63:0]     r_state;
    logic [KW-1:0]   r_key;
    logic [4:0]      r_round;
    logic [KW-1:0]   w_upd, w_inv, w_k32;
    logic [63:0]     w_rk;
    logic            w_hit, w_hit_dec;

    function automatic logic [63:0] sp_layer(input logic [63:0] s);
        logic [63:0] t, o;
        for (int n = 0; n < 16; n++) t[4*n +: 4] = SBOX[{s[4*n +: 4], 2'b00} +: 4];
        for (int i = 0; i < 63; i++) o[(16*i) % 63] = t[i];
        o[63] = t[63];
        return o;
    endfunction

    function automatic logic [63:0] inv_sp_layer(input logic [63:0] s);
        logic [63:0] t, o;
        for (int i = 0; i < 63; i++) t[i] = s[(16*i) % 63];
        t[63] = s[63];
        for (int n = 0; n < 16; n++) o[4*n +: 4] = ISBOX[{t[4*n +: 4], 2'b00} +: 4];
        return o;
    endfunction

    function automatic logic [KW-1:0] key_upd(input logic [KW-1:0] k, input logic [4:0] r);
        logic [KW-1:0] o;
        o = {k[KW-62:0], k[KW-1:KW-61]};
        o[KW-1 -: 4] = SBOX[{o[KW-1 -: 4], 2'b00} +: 4];
        if (KW == 128) o[KW-5 -: 4] = SBOX[{o[KW-5 -: 4], 2'b00} +: 4];
        o[RC_LO +: 5] = o[RC_LO +: 5] ^ r;
        return o;
    endfunction

    function automatic logic [KW-1:0] key_inv_upd(input logic [KW-1:0] k, input logic [4:0] r);
        logic [KW-1:0] o;
        o = k;
        o[RC_LO +: 5] = o[RC_LO +: 5] ^ r;
        o[KW-1 -: 4] = ISBOX[{o[KW-1 -: 4], 2'b00} +: 4];
        if (KW == 128) o[KW-5 -: 4] = ISBOX[{o[KW-5 -: 4], 2'b00} +: 4];
        return {o[60:0], o[KW-1:61]};
    endfunction

    assign w_upd     = key_upd(r_key, r_round);
    assign w_inv     = key_inv_upd(r_key, r_round);
    assign w_rk      = r_key[KW-1 -: 64];
    assign w_hit_dec = in_decrypt && w_hit;

    if (DKEY_CACHE != 0) begin : g_cache
        logic [KW-1:0] r_tag, r_k32;
        logic          r_tag_vld;
        // Tag holds the source key of the expansion in flight; it only becomes valid once its K32 is stored
        always_ff @(posedge clk) begin
            if (rst) begin
                r_tag_vld <= 1'b0;
            end else if (r_fsm == IDLE && in_valid && in_decrypt && !w_hit) begin
                r_tag     <= in_key;
                r_tag_vld <= 1'b0;
            end else if (r_fsm == KEXP && r_round == 5'd31) begin
                r_k32     <= w_upd;
                r_tag_vld <= 1'b1;
            end
        end
        assign w_hit = r_tag_vld && (r_tag == in_key);
        assign w_k32 = r_k32;
    end else begin : g_no_cache
        assign w_hit = 1'b0;
        assign w_k32 = '0;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_fsm <= IDLE;
        else r_fsm <= w_nxt;
    end

    // Next state and handshake/result outputs; the result is masked outside DONE
    always_comb begin
        w_nxt     = r_fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_nxt = !in_decrypt ? ENC : (w_hit ? DEC : KEXP);
            end
            KEXP: w_nxt = (r_round == 5'd31) ? DEC : KEXP;
            ENC:  w_nxt = (r_round == 5'd31) ? DONE : ENC;
            DEC:  w_nxt = (r_round == 5'd1) ? DONE : DEC;
            DONE: begin
                out_valid = 1'b1;
                out_data  = r_state ^ w_rk;
                w_nxt     = out_ready ? IDLE : DONE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, forward key expansion, one cipher round per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
            r_key   <= '0;
            r_round <= '0;
        end else begin
            case (r_fsm)
                IDLE: if (in_valid) begin
                    r_state <= in_data;
                    r_key   <= w_hit_dec ? w_k32 : in_key;
                    r_round <= w_hit_dec ? 5'd31 : 5'd1;
                end
                KEXP: begin
                    r_key   <= w_upd;
                    r_round <= (r_round == 5'd31) ? r_round : r_round + 5'd1;
                end
                ENC: begin
                    r_state <= sp_layer(r_state ^ w_rk);
                    r_key   <= w_upd;
                    r_round <= (r_round == 5'd31) ? r_round : r_round + 5'd1;
                end
                DEC: begin
                    r_state <= inv_sp_layer(r_state ^ w_rk);
                    r_key   <= w_inv;
                    r_round <= r_round - 5'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_present_core_hs.sv
// tb_present_core_hs: randomized bench for present_core_hs against a software PRESENT model
module tb_present_core_hs;
    logic         clk, rst;
    logic         iv[3], ir[3], idec[3], ov[3], ordy[3];
    logic [63:0]  idata[3], od[3];
    logic [127:0] ikey[3];
    int           n_vec, n_err;

    logic [3:0] SB[16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [127:0] mask80 = {48'b0, {80{1'b1}}};

    present_core_hs #(.KEY_WIDTH(80), .DKEY_CACHE(1)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_decrypt(idec[0]),
        .in_data(idata[0]), .in_key(ikey[0][79:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]));
    present_core_hs #(.KEY_WIDTH(80), .DKEY_CACHE(0)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_decrypt(idec[1]),
        .in_data(idata[1]), .in_key(ikey[1][79:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]));
    present_core_hs #(.KEY_WIDTH(128), .DKEY_CACHE(1)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_decrypt(idec[2]),
        .in_data(idata[2]), .in_key(ikey[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

    function automatic logic [63:0] perm(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        int p;
        for (int i = 0; i < 64; i++) begin
            p = (i == 63) ? 63 : (16 * i) % 63;
            if (inv) o[i] = s[p];
            else o[p] = s[i];
        end
        return o;
    endfunction

    function automatic logic [63:0] subs(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        for (int n = 0; n < 16; n++) begin
            if (!inv) o[4*n +: 4] = SB[s[4*n +: 4]];
            else for (int j = 0; j < 16; j++) if (SB[j] == s[4*n +: 4]) o[4*n +: 4] = 4'(j);
        end
        return o;
    endfunction

    function automatic logic [63:0] model(input logic [127:0] key, input int kw, input bit dec, input logic [63:0] x);
        logic [63:0]  rk[1:32];
        logic [127:0] k;
        logic [63:0]  s;
        k = (kw == 80) ? (key & mask80) : key;
        for (int r = 1; r <= 32; r++) begin
            rk[r] = 64'(k >> (kw - 64));
            k = (kw == 80) ? (((k << 61) | (k >> 19)) & mask80) : ((k << 61) | (k >> 67));
            k[kw-1 -: 4] = SB[k[kw-1 -: 4]];
            if (kw == 128) k[kw-5 -: 4] = SB[k[kw-5 -: 4]];
            k = k ^ (128'(r) << ((kw == 80) ? 15 : 62));
        end
        if (!dec) begin
            s = x;
            for (int r = 1; r <= 31; r++) s = perm(subs(s ^ rk[r], 0), 0);
            return s ^ rk[32];
        end
        s = x ^ rk[32];
        for (int r = 31; r >= 1; r--) s = subs(perm(s, 1), 1) ^ rk[r];
        return s;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic xact(input int d, input bit dec, input logic [63:0] data, input logic [127:0] key,
                        input int stall, output logic [63:0] res, output int lat);
        int w;
        res = '0;
        lat = -1;
        w = 0;
        while (!ir[d] && w < 100) begin @(posedge clk); #1; w++; end
        if (!ir[d]) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout dut=%0d in_ready=%b expected 1", d, ir[d]);
            return;
        end
        iv[d] = 1'b1; idec[d] = dec; idata[d] = data; ikey[d] = key;
        @(posedge clk); #1;
        iv[d] = 1'b0; idec[d] = ~dec; idata[d] = {$urandom, $urandom}; ikey[d] = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!ov[d] && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!ov[d]) begin
            n_vec++; n_err++;
            $display("FAIL result_timeout dut=%0d out_valid=%b expected 1", d, ov[d]);
            return;
        end
        for (int i = 0; i < stall; i++) begin @(posedge clk); #1; end
        res = od[d];
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int d = 0; d < 3; d++) begin
            n_vec++; if (ir[d] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready dut=%0d got=%b exp=1", d, ir[d]); end
            n_vec++; if (ov[d] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid dut=%0d got=%b exp=0", d, ov[d]); end
            n_vec++; if (od[d] !== 64'h0) begin n_err++; $display("FAIL reset_out_data dut=%0d got=%h exp=0", d, od[d]); end
        end
    endtask

    task automatic test_kat();
        logic [63:0] res;
        int lat;
        for (int d = 0; d < 2; d++) begin
            xact(d, 0, 64'h0, 128'h0, 0, res, lat);
            n_vec++; if (res !== 64'h5579C1387B228445) begin n_err++; $display("FAIL kat80_zero dut=%0d got=%h exp=5579c1387b228445", d, res); end
            n_vec++; if (lat !== 31) begin n_err++; $display("FAIL kat80_zero_latency dut=%0d got=%0d exp=31", d, lat); end
        end
        xact(2, 0, 64'h0, 128'h0, 0, res, lat);
        n_vec++; if (res !== 64'h96DB702A2E6900AF) begin n_err++; $display("FAIL kat128_zero got=%h exp=96db702a2e6900af", res); end
        n_vec++; if (lat !== 31) begin n_err++; $display("FAIL kat128_zero_latency got=%0d exp=31", lat); end
        for (int rep = 0; rep < 2; rep++) begin
            xact(2, 1, 64'h96DB702A2E6900AF, 128'h0, 0, res, lat);
            n_vec++; if (res !== 64'h0) begin n_err++; $display("FAIL kat128_decrypt rep=%0d got=%h exp=0", rep, res); end
            n_vec++; if (lat !== (rep == 0 ? 62 : 31)) begin n_err++; $display("FAIL kat128_decrypt_latency rep=%0d got=%0d exp=%0d", rep, lat, rep == 0 ? 62 : 31); end
        end
    endtask

    task automatic test_ones();
        logic [63:0]  res;
        logic [127:0] k1;
        int lat;
        k1 = mask80;
        xact(0, 0, '1, k1, 0, res, lat);
        n_vec++; if (res !== 64'h3333DCD3213210D2) begin n_err++; $display("FAIL kat80_ones got=%h exp=3333dcd3213210d2", res); end
        for (int d = 0; d < 2; d++) begin
            for (int rep = 0; rep < 2; rep++) begin
                xact(d, 1, 64'h3333DCD3213210D2, k1, 0, res, lat);
                n_vec++; if (res !== '1) begin n_err++; $display("FAIL kat80_ones_decrypt dut=%0d rep=%0d got=%h exp=ffffffffffffffff", d, rep, res); end
                n_vec++; if (lat !== ((d == 0 && rep == 1) ? 31 : 62)) begin n_err++; $display("FAIL kat80_ones_dec_latency dut=%0d rep=%0d got=%0d exp=%0d", d, rep, lat, (d == 0 && rep == 1) ? 31 : 62); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] key;
        logic [63:0]  data, exp;
        int w;
        key = {$urandom, $urandom, $urandom, $urandom};
        data = {$urandom, $urandom};
        exp = model(key, 128, 0, data);
        n_vec++; if (ir[2] !== 1'b1) begin n_err++; $display("FAIL bp_idle_ready got=%b exp=1", ir[2]); end
        iv[2] = 1'b1; idec[2] = 1'b0; idata[2] = data; ikey[2] = key;
        @(posedge clk); #1;
        iv[2] = 1'b0;
        w = 0;
        while (!ov[2] && w < 200) begin @(posedge clk); #1; w++; end
        n_vec++; if (w !== 31) begin n_err++; $display("FAIL bp_latency got=%0d exp=31", w); end
        iv[2] = 1'b1; idec[2] = 1'b1; idata[2] = ~data; ikey[2] = ~key;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_vec++; if (ov[2] !== 1'b1) begin n_err++; $display("FAIL bp_out_valid cycle=%0d got=%b exp=1", i, ov[2]); end
            n_vec++; if (od[2] !== exp) begin n_err++; $display("FAIL bp_out_data cycle=%0d got=%h exp=%h", i, od[2], exp); end
            n_vec++; if (ir[2] !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", i, ir[2]); end
        end
        iv[2] = 1'b0;
        ordy[2] = 1'b1;
        @(posedge clk); #1;
        ordy[2] = 1'b0;
        n_vec++; if (ir[2] !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_handoff got=%b exp=1", ir[2]); end
        n_vec++; if (ov[2] !== 1'b0) begin n_err++; $display("FAIL bp_valid_after_handoff got=%b exp=0", ov[2]); end
        n_vec++; if (od[2] !== 64'h0) begin n_err++; $display("FAIL bp_data_after_handoff got=%h exp=0", od[2]); end
    endtask

    task automatic test_reset_mid_dec();
        logic [127:0] key;
        logic [63:0]  ct, res, exp;
        int lat;
        key = {48'b0, 16'($urandom), $urandom, $urandom};
        ct = {$urandom, $urandom};
        exp = model(key, 80, 1, ct);
        xact(0, 1, ct, key, 0, res, lat);
        n_vec++; if (res !== exp) begin n_err++; $display("FAIL rst_prime_decrypt got=%h exp=%h", res, exp); end
        iv[0] = 1'b1; idec[0] = 1'b1; idata[0] = ct; ikey[0] = key;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin @(posedge clk); #1; end
        n_vec++; if (ov[0] !== 1'b0) begin n_err++; $display("FAIL rst_mid_dec_busy got=%b exp=0", ov[0]); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (ir[0] !== 1'b1) begin n_err++; $display("FAIL rst_mid_dec_in_ready got=%b exp=1", ir[0]); end
        n_vec++; if (ov[0] !== 1'b0) begin n_err++; $display("FAIL rst_mid_dec_out_valid got=%b exp=0", ov[0]); end
        xact(0, 1, ct, key, 0, res, lat);
        n_vec++; if (res !== exp) begin n_err++; $display("FAIL rst_after_decrypt got=%h exp=%h", res, exp); end
        n_vec++; if (lat !== 62) begin n_err++; $display("FAIL rst_cache_invalidated_latency got=%0d exp=62", lat); end
    endtask

    task automatic test_random();
        logic [127:0] key, lk[3], ckey[3];
        logic [63:0]  data, res, rt, exp;
        bit           cv[3], dec, hit;
        int           d, kw, lat, elat, n;
        apply_reset();
        for (int i = 0; i < 3; i++) begin cv[i] = 1'b0; ckey[i] = '0; lk[i] = {$urandom, $urandom, $urandom, $urandom}; end
        n = 0;
        while (n < 1000 && n_err < 20) begin
            d = $urandom_range(0, 2);
            kw = (d == 2) ? 128 : 80;
            key = $urandom_range(0, 1) ? lk[d] : {$urandom, $urandom, $urandom, $urandom};
            if (kw == 80) key = key & mask80;
            lk[d] = key;
            dec = 1'($urandom_range(0, 1));
            data = {$urandom, $urandom};
            hit = dec && d != 1 && cv[d] && ckey[d] == key;
            exp = model(key, kw, dec, data);
            elat = (!dec || hit) ? 31 : 62;
            xact(d, dec, data, key, $urandom_range(0, 3), res, lat);
            n_vec++; if (res !== exp) begin n_err++; $display("FAIL rand_result n=%0d dut=%0d dec=%0d got=%h exp=%h", n, d, dec, res, exp); end
            n_vec++; if (lat !== elat) begin n_err++; $display("FAIL rand_latency n=%0d dut=%0d dec=%0d got=%0d exp=%0d", n, d, dec, lat, elat); end
            if (dec && d != 1 && !hit) begin cv[d] = 1'b1; ckey[d] = key; end
            n++;
            if (dec) begin
                xact(d, 0, res, key, $urandom_range(0, 2), rt, lat);
                n_vec++; if (rt !== data) begin n_err++; $display("FAIL rand_roundtrip n=%0d dut=%0d got=%h exp=%h", n, d, rt, data); end
                n++;
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; idec[i] = 1'b0; idata[i] = '0; ikey[i] = '0; ordy[i] = 1'b0;
        end
        test_reset();
        test_kat();
        test_ones();
        test_backpressure();
        test_reset_mid_dec();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/present_core_hs.md
# present_core_hs

Parametrised PRESENT block-cipher engine: one round per clock, encryption and decryption, 80- or 128-bit keys. Valid/ready handshakes on both sides replace the bare start/eoc pair of the first-generation core. Decryption first expands the key forward to the last round key. An optional cache skips that expansion when the same key is reused. The block sits between the crypto command front end and the result buffer.

## Interface
- KEY_WIDTH, 128: key length; 80 or 128 only, any other value is an elaboration error.
- DKEY_CACHE, 1: 1 = keep the last expanded decryption key (K32) plus a copy of its source key; 0 = no cache.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at a rising edge.
- in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
- in_data  in  64  plaintext or ciphertext; sampled at accept.
- in_key  in  KEY_WIDTH  cipher key K1; sampled at accept.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  result consumer ready.
- out_data  out  64  result; stable while out_valid is high.

## Operation
- Registers:
  - state: 64 bits.
  - key: KEY_WIDTH bits.
  - round: 5 bits.
  - fsm: IDLE, KEXP, ENC, DEC, DONE.
  - cache, when DKEY_CACHE=1: k32 plus a tag (source key and valid bit).
- Key update upd(k, r):
  - Rotate k left 61 bits.
  - Apply the S-box to the top nibble (80-bit key) or top two nibbles (128-bit key).
  - XOR r into bits [19:15] (80-bit) or [66:62] (128-bit).
- inv_upd(k, r) is the exact inverse: XOR r out, inverse S-box, rotate right 61.
- Round key K_r = key[KEY_WIDTH-1 -: 64].
- IDLE: in_ready = 1. On accept, state <= in_data and round <= 1, then:
  - Encrypt: key <= in_key, go to ENC.
  - Decrypt with a cache hit (DKEY_CACHE=1, tag valid, tag == in_key): key <= cached k32, round <= 31, go to DEC.
  - Decrypt otherwise: key <= in_key, go to KEXP.
- KEXP, edge with round r: key <= upd(key, r).
  - r < 31: round <= r+1.
  - r = 31: round stays 31, go to DEC; the cache is loaded with k32 = upd(key, 31) and its source key.
- ENC, edge with round r: state <= P(S(state ^ K_r)), key <= upd(key, r), round <= r+1. At r = 31, go to DONE.
- DEC, edge with round r: state <= invS(invP(state ^ K_{r+1})), key <= inv_upd(key, r), round <= r-1. At r = 1, go to DONE.
- DONE:
  - out_valid = 1 and out_data = state ^ K_top, where K_top is K32 for encryption and K1 for decryption (the top 64 bits of key in both cases).
  - out_ready high: go to IDLE.
- Outside DONE: out_valid = 0, and out_data is masked to 0.
- S and P are the standard PRESENT S-box and bit permutation (bit i moves to 16*i mod 63, bit 63 fixed). invS and invP are their inverses.

## Timing
- Reset:
  - fsm <= IDLE; state, key and round <= 0; cache tag valid <= 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, out_data = 0.
- Reset asserted in any state aborts the operation. No result is produced for it, and the cache is invalidated.
- Latency is counted from the accept edge to the first cycle with out_valid high:
  - Encrypt: 31 cycles.
  - Decrypt with a cache miss: 62 cycles.
  - Decrypt with a cache hit: 31 cycles.
- in_ready is low in every state except IDLE. Requests are never accepted in DONE, even when out_ready is high.
- After the hand-off edge (DONE and out_ready), the next request can be accepted one cycle later, at the earliest.
- in_data, in_key and in_decrypt are ignored except on the accept edge.
- The round counter never wraps. Values 0 and 32 are never used as round indices.
- An encrypt request does not read or modify the cache.

## Test plan
- PRESENT-80, key 0, plaintext 0, encrypt:
  - out_data = 0x5579C1387B228445.
  - out_valid rises exactly 31 cycles after the accept.
- PRESENT-80, key all-ones, plaintext all-ones, encrypt: 0x3333DCD3213210D2. Then decrypt that result with the same key:
  - DKEY_CACHE=0: returns all-ones at latency 62.
  - DKEY_CACHE=1: first decrypt takes 62 cycles; a repeat with the same key takes 31 cycles.
- PRESENT-128, key 0, plaintext 0, encrypt: 0x96DB702A2E6900AF. Decrypting it returns 0.
- Backpressure: hold out_ready low for 10 cycles in DONE.
  - out_valid and out_data stay stable throughout.
  - in_ready stays 0, and a request presented meanwhile is not accepted.
  - After out_ready rises, in_ready is 1 on the next cycle.
- Assert rst mid-DEC at round 15:
  - Next cycle: in_ready = 1 and out_valid = 0.
  - A following decrypt with the same key misses the cache (62-cycle latency).
- Random regression: 1000 random (key, data, mode) requests with random out_ready stalls, checked against a software PRESENT model. A decrypt followed by an encrypt of the result must round-trip.
